// File: rtl/sample_pacer.sv
// Sample pacer: buffers received audio bytes and releases them one per
// sample period at the selected rate, with priming and underrun counting.
module sample_pacer #(
    parameter int CLK_HZ      = 12000000,
    parameter int FIFO_DEPTH  = 64,
    parameter int PRIME_LEVEL = FIFO_DEPTH / 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [2:0]                    tiempo_sel,
    input  logic                          rx_rq,
    input  logic [7:0]                    dato_rx,
    output logic                          rx_st,
    output logic [7:0]                    sample_out,
    output logic                          sample_stb,
    output logic                          playing,
    output logic [7:0]                    underrun_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    localparam logic [PTR_W-1:0] PRIME_L = PTR_W'(PRIME_LEVEL);

    function automatic logic [15:0] div_of(input int code);
        int rate;
        case (code)
            0:       rate = 8000;
            1:       rate = 11025;
            2:       rate = 16000;
            3:       rate = 22050;
            4:       rate = 24000;
            5:       rate = 32000;
            6:       rate = 44100;
            default: rate = 48000;
        endcase
        return 16'((CLK_HZ + rate / 2) / rate);
    endfunction

    localparam logic [15:0] DIV_TAB [8] = '{
        div_of(0), div_of(1), div_of(2), div_of(3),
        div_of(4), div_of(5), div_of(6), div_of(7)
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_PLAY  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             rx_rq_r_q;
    logic             rx_st_q, rx_st_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [15:0]      tick_q, tick_d;
    logic [15:0]      dtv_q, dtv_d;
    logic [7:0]       sample_q, sample_d;
    logic             stb_q, stb_d;
    logic [7:0]       urun_q, urun_d;
    logic [7:0]       mem_q [FIFO_DEPTH];

    logic             full;
    logic             empty;
    logic             wr_en;
    logic             tick;
    logic [PTR_W-1:0] level;

    assign level = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign tick  = (state_q == S_PLAY) && (tick_q == dtv_q - 16'd1);

    always_comb begin
        state_d  = state_q;
        rx_st_d  = rx_st_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        tick_d   = tick_q;
        dtv_d    = dtv_q;
        sample_d = sample_q;
        stb_d    = 1'b0;
        urun_d   = urun_q;
        wr_en    = 1'b0;

        if (!enable) begin
            // Dropping enable flushes everything, including a byte mid-handshake
            state_d  = S_IDLE;
            rx_st_d  = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            tick_d   = '0;
            dtv_d    = DIV_TAB[tiempo_sel];
        end else begin
            if (rx_rq_r_q && !rx_st_q && !full) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                rx_st_d  = 1'b1;
            end else if (!rx_rq_r_q && rx_st_q) begin
                rx_st_d = 1'b0;
            end

            unique case (state_q)
                S_IDLE: begin
                    tick_d  = '0;
                    state_d = S_PRIME;
                end
                S_PRIME: begin
                    tick_d = '0;
                    if (level >= PRIME_L) begin
                        dtv_d   = DIV_TAB[tiempo_sel];
                        state_d = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (tick) begin
                        tick_d = '0;
                        if (!empty) begin
                            sample_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
                            stb_d    = 1'b1;
                            rd_ptr_d = rd_ptr_q + PTR_W'(1);
                        end else begin
                            if (urun_q != 8'hFF) begin
                                urun_d = urun_q + 8'd1;
                            end
                            state_d = S_PRIME;
                        end
                    end else begin
                        tick_d = tick_q + 16'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rx_rq_r_q <= 1'b0;
            rx_st_q   <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            tick_q    <= '0;
            dtv_q     <= DIV_TAB[tiempo_sel];
            sample_q  <= 8'h00;
            stb_q     <= 1'b0;
            urun_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            rx_rq_r_q <= rx_rq;
            rx_st_q   <= rx_st_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            tick_q    <= tick_d;
            dtv_q     <= dtv_d;
            sample_q  <= sample_d;
            stb_q     <= stb_d;
            urun_q    <= urun_d;
        end
    end

    // Storage needs no reset; occupancy is defined by the pointers alone
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= dato_rx;
        end
    end

    assign rx_st        = rx_st_q;
    assign sample_out   = sample_q;
    assign sample_stb   = stb_q;
    assign playing      = (state_q == S_PLAY);
    assign underrun_cnt = urun_q;
    assign fifo_level   = level;

endmodule

// File: doc/sample_pacer.md
# sample_pacer

Downstream stage of the link-initialisation block. Once initialisation reports success, it accepts 8-bit audio sample bytes from the serial receive path over the rx_rq/rx_st four-phase handshake and buffers them in a FIFO. It releases them one per sample period at the rate selected by tiempo_sel, producing a strobed sample stream for the output (PWM/DAC) stage. It applies backpressure when full, primes before playback, and counts underruns.

## Interface
- CLK_HZ, 12000000: system clock frequency in Hz; every divisor must fit in 16 bits.
- FIFO_DEPTH, 64: sample buffer depth; power of two, at least 4.
- PRIME_LEVEL, FIFO_DEPTH/2: FIFO occupancy required before playback starts.
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  high while initialisation has completed successfully; low flushes and idles the block
- tiempo_sel  in  3  sample-rate code: 0=8000, 1=11025, 2=16000, 3=22050, 4=24000, 5=32000, 6=44100, 7=48000 Sps
- rx_rq  in  1  byte request from the receive path; dato_rx is valid while it is high
- dato_rx  in  8  received byte
- rx_st  out  1  acknowledge for the four-phase handshake
- sample_out  out  8  current output sample; holds its value between strobes
- sample_stb  out  1  one-cycle pulse when sample_out updates
- playing  out  1  high in the PLAY state
- underrun_cnt  out  8  underrun count, saturates at 255
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy

## Operation
- Divisor DIV for each code = (CLK_HZ + rate/2) / rate, computed at elaboration. At 12 MHz the divisors are 1500, 1088, 750, 544, 500, 375, 272, 250.
- rx_rq passes through one register stage (rx_rq_r) before use.
- Receive handshake:
  - If rx_rq_r=1, rx_st=0, FIFO not full and enable=1: write dato_rx into the FIFO and set rx_st<=1.
  - If rx_rq_r=0 and rx_st=1: set rx_st<=0.
  - A full FIFO withholds rx_st, which stalls the sender. No byte is ever dropped.
- States:
  - IDLE: entered on reset or whenever enable=0, from any state, on the next cycle. On entry, flush the FIFO (pointers to 0), clear rx_st, clear the tick counter and reset dtv<=DIV[tiempo_sel]. On enable=1, go to PRIME.
  - PRIME: accept bytes, tick counter held at 0. When fifo_level >= PRIME_LEVEL, latch DIV from tiempo_sel and go to PLAY.
  - PLAY: the tick counter counts 0..DIV-1; the cycle where it equals DIV-1 is a tick and the counter returns to 0.
    - Tick with FIFO not empty: sample_out<=head, pulse sample_stb, advance the read pointer.
    - Tick with FIFO empty: sample_out holds, no strobe, underrun_cnt increments (saturating), go to PRIME.
- tiempo_sel is sampled only on the PRIME->PLAY transition. Changes during PLAY take effect after the next re-prime.
- Simultaneous FIFO write and read in one cycle: both occur, fifo_level is unchanged. Full/empty are evaluated from start-of-cycle state.
- Pointers are ADDR_W+1 bits wide and wrap modulo 2*FIFO_DEPTH. Full = MSBs differ and the rest are equal.

## Timing
- Reset values: rx_st=0, sample_out=0x00, sample_stb=0, playing=0, underrun_cnt=0, fifo_level=0, state IDLE.
- rx_st rises on the second clk edge after rx_rq rises (one synchroniser edge plus one registered edge).
- rx_st falls on the second edge after rx_rq falls.
- Byte-to-FIFO latency: the byte is visible in fifo_level on the same edge that rx_st rises.
- The first sample_stb occurs DIV cycles after the edge that enters PLAY. After that, strobes come exactly every DIV cycles while data is available.
- sample_stb is high for exactly one cycle. sample_out changes on the same edge that raises sample_stb.
- Reset or enable=0 mid-handshake: rx_st drops on the next edge and the in-flight byte is discarded. The sender must restart the handshake.

## Test plan
- Reset, then enable=1, tiempo_sel=7 (12 MHz), send 32 bytes 0x00..0x1F: PLAY entered after the 32nd write; strobes every 250 cycles carrying 0x00, 0x01, … in order.
- Send 64 bytes with no drain (enable=1, still PRIME or slow rate): the 65th rx_rq gets no rx_st until a read frees a slot; fifo_level never exceeds 64 and no byte is lost.
- In PLAY at tiempo_sel=0, stop sending: after the FIFO drains, the next tick produces no strobe, sample_out holds its last value, underrun_cnt=1 and state returns to PRIME.
- Change tiempo_sel from 7 to 1 during PLAY: strobe spacing stays 250 until an underrun plus re-prime, then becomes 1088.
- A write and a tick on the same cycle with fifo_level=10: level stays 10 and the correct head byte is output.
- Drop enable mid-handshake (rx_st=1): rx_st=0, fifo_level=0, playing=0 on the next edge. After re-enable, priming restarts from empty.
